dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 105 ++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data memory behind a simple request port.
// After reset a sweep zeroes every word (CLEAR), then requests are served (RUN).
// Reads return registered data one cycle after acceptance; writes are posted
// through a one-entry buffer that commits on the following edge, and reads of
// the buffered index are forwarded from the buffer.
module dmem_responder #(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        MemoryEnable,
  input  logic        ReadNotWrite,
  input  logic [31:0] DRAMadd,
  input  logic [31:0] DRAMin,
  output logic [31:0] DRAMout,
  output logic        Ready,
  output logic        AddrErr,
  output logic [0:0]  dbg_state
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;

  localparam logic [DEPTH_LOG2-1:0] CNT_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  // Handshake: a request is taken on a rising edge where MemoryEnable=1 and
  // Ready=1. Ready is registered and stays high for the whole RUN phase, so
  // every valid cycle in RUN is one accepted request; in CLEAR valid is
  // ignored outright (no error pulse, no side effect).

  logic [0:0]            state;
  logic [DEPTH_LOG2-1:0] sweep_cnt;
  logic                  ready_q;

  logic                  buf_valid;
  logic [DEPTH_LOG2-1:0] buf_idx;
  logic [31:0]           buf_data;

  logic [31:0]           mem [DEPTH];

  logic                  accept;
  logic                  addr_ok;
  logic [DEPTH_LOG2-1:0] req_idx;
  logic [31:0]           read_word;

  // Decode the request: acceptance, alignment/range check, index, forwarded read data.
  always_comb begin
    accept    = MemoryEnable && ready_q;
    addr_ok   = (DRAMadd[1:0] == 2'b00) && !(|DRAMadd[31:DEPTH_LOG2+2]);
    req_idx   = DRAMadd[DEPTH_LOG2+1:2];
    read_word = (buf_valid && (buf_idx == req_idx)) ? buf_data : mem[req_idx];
  end

  // Array write port: sweep zeroes during CLEAR, posted-buffer commit during RUN.
  always_ff @(posedge Clk) begin
    if (state == CLEAR) begin
      mem[sweep_cnt] <= '0;
    end else if (buf_valid) begin
      mem[buf_idx] <= buf_data;
    end
  end

  // Control state, sweep counter, posted buffer, read data and error pulse.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state     <= CLEAR;
      sweep_cnt <= '0;
      ready_q   <= 1'b0;
      buf_valid <= 1'b0;
      buf_idx   <= '0;
      buf_data  <= '0;
      DRAMout   <= '0;
      AddrErr   <= 1'b0;
    end else begin
      AddrErr <= 1'b0;
      if (state == CLEAR) begin
        sweep_cnt <= sweep_cnt + CNT_ONE;
        if (&sweep_cnt) begin
          state   <= RUN;
          ready_q <= 1'b1;
        end
      end else begin
        // Any entry held now is committed by the array port at this edge.
        buf_valid <= 1'b0;
        if (accept) begin
          if (!addr_ok) begin
            AddrErr <= 1'b1;
          end else if (ReadNotWrite) begin
            DRAMout <= read_word;
          end else begin
            buf_valid <= 1'b1;
            buf_idx   <= req_idx;
            buf_data  <= DRAMin;
          end
        end
      end
    end
  end

  assign Ready     = ready_q;
  assign dbg_state = state;

endmodule
